// File: rtl/seg7_pkg.sv
// Package for the multiplexed 7-segment driver.
// Holds the segment codes ({a,b,c,d,e,f,g}, active-high, bit6 = a), the
// BCD-to-segment decoder, the overflow-limit helper and the converter state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110010;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_e;

    // Codes 10..15 cannot come out of the converter; they decode to blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Largest value that fits in n decimal digits (10**n - 1).
    function automatic logic [31:0] pow10_minus1(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between a host and seg7_scan_driver.
//   en, load, value      host -> driver (display enable, load strobe, binary value)
//   busy, overflow       driver -> host (conversion running, value out of range)
//   seg, dig_sel         driver -> display (shared segment bus, one-hot digit select)
// master = host/testbench side, slave = driver side.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 2,
    parameter int VALUE_W    = 8
);
    logic                  en;
    logic                  load;
    logic [VALUE_W-1:0]    value;
    logic                  busy;
    logic                  overflow;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] dig_sel;

    modport master (output en, load, value, input busy, overflow, seg, dig_sel);
    modport slave  (input en, load, value, output busy, overflow, seg, dig_sel);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// One bit per cycle: IDLE -> CONV (VALUE_W cycles) -> DONE (1 cycle) -> IDLE.
//   clk, rst   clock, async active-high reset
//   start_i    start strobe, honoured only in IDLE
//   bin_i      binary operand, captured with start_i
//   busy_o     high in CONV and DONE
//   done_o     high for the single DONE cycle; bcd_o is final then
//   bcd_o      NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]
// Values needing more digits than NUM_DIGITS leave a truncated result; the
// caller flags those as overflow and does not display the digits.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int VALUE_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [VALUE_W-1:0]      bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);
    localparam int CNT_W = $clog2(VALUE_W + 1);

    conv_state_e             state_q, state_d;
    logic [VALUE_W-1:0]      sh_q, sh_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Any digit >= 5 gets +3 so the following left shift carries into the next digit.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                             : bcd_q[4*i +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CONV;
                    sh_d    = bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[4*NUM_DIGITS-2:0], sh_q[VALUE_W-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit time-multiplexed 7-segment driver.
// A loaded binary value is converted to BCD by bin2bcd_seq, latched into the
// display register on DONE, and the digits are scanned onto one shared segment
// bus with a one-hot digit select. Digit 0 is the least significant.
//   clk, rst   clock, async active-high reset
//   bus        seg7_scan_driver_if.slave: en, load, value in; busy, overflow, seg, dig_sel out
// Build option: define SEG7_LZB_EN for leading-zero blanking (digit 0 is never
// blanked, overflow dashes are never blanked). Undefined: digits are zero-padded.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int VALUE_W     = 8,
    parameter int REFRESH_DIV = 1000
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int          IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int          DIV_W     = $clog2(REFRESH_DIV);
    localparam logic [31:0] MAX_SHOWN = pow10_minus1(NUM_DIGITS);

    logic                    conv_busy, conv_done, accept;
    logic [4*NUM_DIGITS-1:0] conv_bcd;

    logic [4*NUM_DIGITS-1:0] disp_q;
    logic                    ovf_pend_q, overflow_q;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic [NUM_DIGITS-1:0][6:0] dseg;

    assign accept = bus.load && !conv_busy;

    bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS), .VALUE_W(VALUE_W)) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (bus.load),
        .bin_i   (bus.value),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Per-digit segment pattern from the display register.
`ifdef SEG7_LZB_EN
    // upper_zero[i]: digits i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS:1] upper_zero;
    assign upper_zero[NUM_DIGITS] = 1'b1;
`endif
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic blank;
`ifdef SEG7_LZB_EN
        if (i > 0) begin : g_lz
            assign upper_zero[i] = upper_zero[i+1] && (disp_q[4*i +: 4] == 4'd0);
            assign blank         = upper_zero[i];
        end else begin : g_lsd
            assign blank = 1'b0;
        end
`else
        assign blank = 1'b0;
`endif
        assign dseg[i] = overflow_q ? SEG_DASH :
                         blank      ? SEG_BLANK : bcd_to_seg(disp_q[4*i +: 4]);
    end

    // Scan timing runs regardless of en so re-enabling resumes mid-sequence.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // seg and dig_sel come from one register stage so they switch together.
    always_comb begin
        seg_d = SEG_BLANK;
        dig_d = '0;
        if (bus.en) begin
            seg_d = dseg[idx_q];
            dig_d = NUM_DIGITS'(1) << idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q     <= '0;
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            div_q      <= '0;
            idx_q      <= '0;
            seg_q      <= '0;
            dig_q      <= '0;
        end else begin
            // Range is judged on the captured value, not on the truncated BCD.
            if (accept) ovf_pend_q <= (32'(bus.value) > MAX_SHOWN);
            if (conv_done) begin
                disp_q     <= conv_bcd;
                overflow_q <= ovf_pend_q;
            end
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign bus.busy     = conv_busy;
    assign bus.overflow = overflow_q;
    assign bus.seg      = seg_q;
    assign bus.dig_sel  = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                           S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111,
                           S7 = 7'b1110010, S9 = 7'b1111011, SD = 7'b0000001;
`ifdef SEG7_LZB_EN
    localparam logic [6:0] LZ = 7'b0000000;  // leading zero is blanked
`else
    localparam logic [6:0] LZ = S0;          // leading zero is shown
`endif

    typedef struct packed {
        logic           ovf;
        logic [2:0][6:0] seg;  // seg[k] = expected pattern on digit k
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(2), .VALUE_W(8))  if2 ();
    seg7_scan_driver_if #(.NUM_DIGITS(3), .VALUE_W(10)) if3 ();

    seg7_scan_driver #(.NUM_DIGITS(2), .VALUE_W(8), .REFRESH_DIV(4)) dut2 (
        .clk(clk), .rst(rst), .bus(if2));
    seg7_scan_driver #(.NUM_DIGITS(3), .VALUE_W(10), .REFRESH_DIV(4)) dut3 (
        .clk(clk), .rst(rst), .bus(if3));

    logic       busy_w [2];
    logic       ovf_w  [2];
    logic [6:0] seg_w  [2];
    logic [7:0] dsel_w [2];
    assign busy_w[0] = if2.busy;      assign busy_w[1] = if3.busy;
    assign ovf_w[0]  = if2.overflow;  assign ovf_w[1]  = if3.overflow;
    assign seg_w[0]  = if2.seg;       assign seg_w[1]  = if3.seg;
    assign dsel_w[0] = 8'(if2.dig_sel);
    assign dsel_w[1] = 8'(if3.dig_sel);

    exp_t q2[$];
    exp_t q3[$];
    int   ndone [2];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a falling busy edge marks a finished conversion; pop
    // the expectation and compare overflow, busy width and every scanned digit.
    task automatic monitor(input int d);
        int         hi   = 0;
        int         nd   = (d == 0) ? 2 : 3;
        int         blen = (d == 0) ? 9 : 11;  // VALUE_W CONV cycles + DONE
        logic [2:0] mask = (d == 0) ? 3'b011 : 3'b111;
        logic [2:0] seen;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) hi = 0;
            else if (busy_w[d]) hi++;
            else if (hi != 0) begin
                chk($sformatf("busy_width_dut%0d", d), hi, blen);
                hi = 0;
                if ((d == 0 && q2.size() == 0) || (d == 1 && q3.size() == 0)) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_conversion dut%0d: got a result, expected none", d);
                end else begin
                    if (d == 0) e = q2.pop_front();
                    else        e = q3.pop_front();
                    chk($sformatf("overflow_dut%0d", d), ovf_w[d], e.ovf);
                    seen = '0;
                    for (int c = 0; c < nd * 4 + 4 && seen != mask; c++) begin
                        @(negedge clk);
                        for (int k = 0; k < nd; k++)
                            if (dsel_w[d] == (8'd1 << k) && !seen[k]) begin
                                chk($sformatf("seg_dut%0d_dig%0d", d, k), seg_w[d], e.seg[k]);
                                seen[k] = 1'b1;
                            end
                    end
                    chk($sformatf("scan_cover_dut%0d", d), seen, mask);
                    ndone[d]++;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic pulse_load(input int d, input int v);
        @(negedge clk);
        if (d == 0) begin if2.value = 8'(v);  if2.load = 1'b1; end
        else        begin if3.value = 10'(v); if3.load = 1'b1; end
        @(negedge clk);
        if2.load = 1'b0;
        if3.load = 1'b0;
    endtask

    // Issue one conversion and queue its expected display. ign >= 0 is an
    // extra load issued while busy, which must be dropped.
    task automatic conv(input int d, input int v, input int ign, input logic ovf,
                        input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
        exp_t e;
        int   start = ndone[d];
        e.ovf = ovf;
        e.seg = {s2, s1, s0};
        if (d == 0) q2.push_back(e); else q3.push_back(e);
        pulse_load(d, v);
        if (ign >= 0) begin
            repeat (2) @(negedge clk);
            pulse_load(d, ign);
        end
        for (int c = 0; c < 300 && ndone[d] == start; c++) @(negedge clk);
        chk($sformatf("conv_done_dut%0d_v%0d", d, v), ndone[d] - start, 1);
    endtask

    task automatic pulse_reset_and_check(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_seg"},  if2.seg, 7'd0);
        chk({tag, "_dsel"}, if2.dig_sel, 2'd0);
        chk({tag, "_busy"}, if2.busy, 1'b0);
        chk({tag, "_ovf"},  if2.overflow, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Display register must be back to zero: digit 0 shows '0'.
        for (int c = 0; c < 20 && dsel_w[0] != 8'd1; c++) @(negedge clk);
        chk({tag, "_zero_dsel"}, dsel_w[0], 8'd1);
        chk({tag, "_zero_seg"},  if2.seg, S0);
    endtask

    initial begin
        logic [7:0] prev;
        logic [2:0] pat [4];
        pat[0] = 3'b001; pat[1] = 3'b010; pat[2] = 3'b100; pat[3] = 3'b001;
        if2.en = 1'b1; if2.load = 1'b0; if2.value = '0;
        if3.en = 1'b1; if3.load = 1'b0; if3.value = '0;

        @(negedge clk);
        chk("rst_seg",   if2.seg, 7'd0);
        chk("rst_dsel",  if2.dig_sel, 2'd0);
        chk("rst_busy",  if2.busy, 1'b0);
        chk("rst_ovf",   if2.overflow, 1'b0);
        chk("rst_dsel3", if3.dig_sel, 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Digit 0 is least significant: 42 shows '2' on dig_sel[0], '4' on dig_sel[1].
        conv(0, 42, -1, 1'b0, 7'd0, S4, S2);
        pulse_reset_and_check("rst_midscan");
        conv(0, 123, -1, 1'b1, 7'd0, SD, SD);
        conv(0, 5,   -1, 1'b0, 7'd0, LZ, S5);
        conv(0, 99,  -1, 1'b0, 7'd0, S9, S9);
        conv(0, 100, -1, 1'b1, 7'd0, SD, SD);
        conv(0, 60,  99, 1'b0, 7'd0, S6, S0);
        repeat (30) @(negedge clk);  // a wrongly accepted 99 would show up here

        // Reset while converting: no result, display cleared.
        pulse_load(0, 77);
        repeat (3) @(negedge clk);
        pulse_reset_and_check("rst_midconv");

        conv(1, 7,    -1, 1'b0, LZ, LZ, S7);
        conv(1, 0,    -1, 1'b0, LZ, LZ, S0);
        conv(1, 205,  -1, 1'b0, S2, S0, S5);
        conv(1, 1000, -1, 1'b1, SD, SD, SD);
        conv(1, 10,   -1, 1'b0, LZ, S1, S0);

        // Scan order and hold time on the 3-digit instance.
        prev = dsel_w[1];
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dsel_w[1] == 8'd1 && prev != 8'd1) break;
            prev = dsel_w[1];
        end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) begin
                if (k > 0 || j > 0) @(negedge clk);
                chk($sformatf("scan_seq_%0d_%0d", k, j), dsel_w[1], 8'(pat[k]));
            end
        if3.en = 1'b0;
        @(negedge clk);
        chk("en_off_dsel", dsel_w[1], 8'd0);
        chk("en_off_seg",  seg_w[1], 7'd0);
        if3.en = 1'b1;
        @(negedge clk);
        chk("en_on_onehot", $countones(dsel_w[1]), 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
